// File: rtl/tremolo_param_pkg.sv
// Shared definitions for the tremolo parameter bank.
// Holds the per-channel register offsets, AXI response codes, the waveform enum,
// the write/read FSM state types, the write-request and shadow-register structs,
// and a byte-strobe merge helper.
package tremolo_param_pkg;

  localparam logic [1:0] REG_DEPTH  = 2'd0;
  localparam logic [1:0] REG_RATE   = 2'd1;
  localparam logic [1:0] REG_WAVE   = 2'd2;
  localparam logic [1:0] REG_ENABLE = 2'd3;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {WAVE_SINE, WAVE_TRI, WAVE_SQUARE, WAVE_SAW} wave_e;
  typedef enum logic {W_IDLE, W_RESP} wr_state_e;
  typedef enum logic {R_IDLE, R_DATA} rd_state_e;

  // One decoded write beat aimed at a single channel.
  typedef struct packed {
    logic        en;
    logic [1:0]  sel;
    logic [31:0] data;
    logic [3:0]  strb;
  } wr_req_t;

  // Shadow (CPU-visible) copy of one channel.
  typedef struct packed {
    logic [31:0] depth;
    logic [31:0] rate;
    wave_e       wave;
    logic        enable;
  } ch_regs_t;

  function automatic logic [31:0] apply_strb(input logic [31:0] old, input logic [31:0] data,
                                             input logic [3:0] strb);
    logic [31:0] r;
    for (int b = 0; b < 4; b++) r[8*b +: 8] = strb[b] ? data[8*b +: 8] : old[8*b +: 8];
    return r;
  endfunction

endpackage

// File: rtl/tremolo_param_channel.sv
// One channel of the tremolo parameter bank: shadow registers written from the
// bus, and active registers loaded from the shadow on commit.
// Ports:
//   clk, rst          clock, async active-high reset
//   req               decoded write beat for this channel
//   commit            one-cycle strobe: copy shadow -> active
//   shadow            shadow registers (read back over the bus)
//   depth/rate        active parameters, truncated to PARAM_W
//   wave/enable       active waveform select and enable
module tremolo_param_channel
  import tremolo_param_pkg::*;
#(
  parameter int PARAM_W = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  wr_req_t            req,
  input  logic               commit,
  output ch_regs_t           shadow,
  output logic [PARAM_W-1:0] depth,
  output logic [PARAM_W-1:0] rate,
  output logic [1:0]         wave,
  output logic               enable
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shadow <= '0;
      depth  <= '0;
      rate   <= '0;
      wave   <= '0;
      enable <= 1'b0;
    end else begin
      if (req.en) begin
        case (req.sel)
          REG_DEPTH: shadow.depth <= apply_strb(shadow.depth, req.data, req.strb);
          REG_RATE:  shadow.rate  <= apply_strb(shadow.rate, req.data, req.strb);
          REG_WAVE:  if (req.strb[0]) shadow.wave <= wave_e'(req.data[1:0]);
          default:   if (req.strb[0]) shadow.enable <= req.data[0];
        endcase
      end
      // Non-blocking: a write landing on the commit edge is not seen here,
      // so active takes the pre-write shadow value.
      if (commit) begin
        depth  <= shadow.depth[PARAM_W-1:0];
        rate   <= shadow.rate[PARAM_W-1:0];
        wave   <= shadow.wave;
        enable <= shadow.enable;
      end
    end
  end

endmodule

// File: rtl/axi_tremolo_param_bank.sv
// AXI4-Lite slave holding double-buffered tremolo parameters for NUM_CH channels.
// The CPU writes shadow registers; they move to the active outputs only on a
// sample_tick while a commit is pending or AUTO is set.
// Ports:
//   ACLK, ARESET          clock, async active-high reset
//   S_AXI_*               AXI4-Lite slave (AW/W/B write, AR/R read)
//   sample_tick           one-cycle strobe per audio sample
//   depth_o, rate_o       active parameters, ch c at [c*PARAM_W +: PARAM_W]
//   wave_o                active waveform, ch c at [2*c +: 2]
//   enable_o              active enables, one bit per channel
// Map (word index = addr[ADDR_W-1:2]): 4*c+r channel regs, 4*NUM_CH CTRL,
// 4*NUM_CH+1 STATUS, anything above is SLVERR.
module axi_tremolo_param_bank
  import tremolo_param_pkg::*;
#(
  parameter int NUM_CH             = 2,
  parameter int PARAM_W            = 16,
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int C_S_AXI_ADDR_WIDTH = 6
) (
  input  logic                            ACLK,
  input  logic                            ARESET,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_AWADDR,
  input  logic                            S_AXI_AWVALID,
  output logic                            S_AXI_AWREADY,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_WDATA,
  input  logic [3:0]                      S_AXI_WSTRB,
  input  logic                            S_AXI_WVALID,
  output logic                            S_AXI_WREADY,
  output logic [1:0]                      S_AXI_BRESP,
  output logic                            S_AXI_BVALID,
  input  logic                            S_AXI_BREADY,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_ARADDR,
  input  logic                            S_AXI_ARVALID,
  output logic                            S_AXI_ARREADY,
  output logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_RDATA,
  output logic [1:0]                      S_AXI_RRESP,
  output logic                            S_AXI_RVALID,
  input  logic                            S_AXI_RREADY,
  input  logic                            sample_tick,
  output logic [NUM_CH*PARAM_W-1:0]       depth_o,
  output logic [NUM_CH*PARAM_W-1:0]       rate_o,
  output logic [NUM_CH*2-1:0]             wave_o,
  output logic [NUM_CH-1:0]               enable_o
);

  localparam int AW       = C_S_AXI_ADDR_WIDTH;
  localparam int CTRL_IDX = 4 * NUM_CH;
  localparam int STAT_IDX = CTRL_IDX + 1;

  // ---------------- write path ----------------
  wr_state_e         w_state, w_next;
  logic              aw_got, w_got;
  logic [AW-1:0]     aw_addr;
  logic [31:0]       w_data;
  logic [3:0]        w_strb;
  logic [1:0]        bresp;
  logic              do_wr;
  int                w_i;

  assign w_i   = 32'(aw_addr[AW-1:2]);
  // Apply happens in the cycle both beats are held; READYs are already low.
  assign do_wr = (w_state == W_IDLE) && aw_got && w_got;

  // Gated by reset so the bus sees not-ready while reset is held.
  assign S_AXI_AWREADY = !ARESET && (w_state == W_IDLE) && !aw_got;
  assign S_AXI_WREADY  = !ARESET && (w_state == W_IDLE) && !w_got;
  assign S_AXI_BVALID  = (w_state == W_RESP);
  assign S_AXI_BRESP   = bresp;

  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) w_state <= W_IDLE;
    else        w_state <= w_next;
  end

  always_comb begin
    w_next = w_state;
    case (w_state)
      W_IDLE:  if (aw_got && w_got) w_next = W_RESP;
      W_RESP:  if (S_AXI_BREADY) w_next = W_IDLE;
      default: w_next = W_IDLE;
    endcase
  end

  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      aw_got  <= 1'b0;
      w_got   <= 1'b0;
      aw_addr <= '0;
      w_data  <= '0;
      w_strb  <= '0;
      bresp   <= RESP_OKAY;
    end else begin
      if (S_AXI_AWVALID && S_AXI_AWREADY) begin
        aw_got  <= 1'b1;
        aw_addr <= S_AXI_AWADDR;
      end
      if (S_AXI_WVALID && S_AXI_WREADY) begin
        w_got  <= 1'b1;
        w_data <= S_AXI_WDATA;
        w_strb <= S_AXI_WSTRB;
      end
      if (do_wr) begin
        aw_got <= 1'b0;
        w_got  <= 1'b0;
        bresp  <= (w_i > STAT_IDX) ? RESP_SLVERR : RESP_OKAY;
      end
    end
  end

  // ---------------- CTRL / STATUS ----------------
  logic auto_en, pending, commit_wr, transfer;

  assign commit_wr = do_wr && (w_i == CTRL_IDX) && w_strb[0] && w_data[0];
  assign transfer  = sample_tick && (pending || auto_en);

  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      auto_en <= 1'b0;
      pending <= 1'b0;
    end else begin
      if (do_wr && (w_i == CTRL_IDX) && w_strb[0]) auto_en <= w_data[1];
      // A commit landing on a tick wins: it stays pending for the next tick.
      if (commit_wr)     pending <= 1'b1;
      else if (transfer) pending <= 1'b0;
    end
  end

  // ---------------- channels ----------------
  wr_req_t  [NUM_CH-1:0] ch_req;
  ch_regs_t [NUM_CH-1:0] sh;

  always_comb begin
    for (int c = 0; c < NUM_CH; c++) begin
      ch_req[c].en   = do_wr && (w_i < CTRL_IDX) && ((w_i >> 2) == c);
      ch_req[c].sel  = aw_addr[3:2];
      ch_req[c].data = w_data;
      ch_req[c].strb = w_strb;
    end
  end

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    tremolo_param_channel #(.PARAM_W(PARAM_W)) u_ch (
      .clk    (ACLK),
      .rst    (ARESET),
      .req    (ch_req[c]),
      .commit (transfer),
      .shadow (sh[c]),
      .depth  (depth_o[c*PARAM_W +: PARAM_W]),
      .rate   (rate_o[c*PARAM_W +: PARAM_W]),
      .wave   (wave_o[2*c +: 2]),
      .enable (enable_o[c])
    );
  end

  // ---------------- read path ----------------
  rd_state_e   r_state, r_next;
  logic [31:0] rdata, rd_val;
  logic [1:0]  rresp, rd_resp;
  int          r_i;

  assign r_i           = 32'(S_AXI_ARADDR[AW-1:2]);
  assign S_AXI_ARREADY = !ARESET && (r_state == R_IDLE);
  assign S_AXI_RVALID  = (r_state == R_DATA);
  assign S_AXI_RDATA   = rdata;
  assign S_AXI_RRESP   = rresp;

  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) r_state <= R_IDLE;
    else        r_state <= r_next;
  end

  always_comb begin
    r_next = r_state;
    case (r_state)
      R_IDLE:  if (S_AXI_ARVALID) r_next = R_DATA;
      R_DATA:  if (S_AXI_RREADY) r_next = R_IDLE;
      default: r_next = R_IDLE;
    endcase
  end

  always_comb begin
    rd_val  = '0;
    rd_resp = RESP_OKAY;
    if (r_i < CTRL_IDX) begin
      for (int c = 0; c < NUM_CH; c++) begin
        if ((r_i >> 2) == c) begin
          case (S_AXI_ARADDR[3:2])
            REG_DEPTH: rd_val = sh[c].depth;
            REG_RATE:  rd_val = sh[c].rate;
            REG_WAVE:  rd_val = {30'b0, sh[c].wave};
            default:   rd_val = {31'b0, sh[c].enable};
          endcase
        end
      end
    end else if (r_i == CTRL_IDX) begin
      rd_val = {30'b0, auto_en, 1'b0};
    end else if (r_i == STAT_IDX) begin
      rd_val = {31'b0, pending};
    end else begin
      rd_resp = RESP_SLVERR;
    end
  end

  // Captured at the AR edge, so a write landing that same edge reads old data.
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      rdata <= '0;
      rresp <= RESP_OKAY;
    end else if (S_AXI_ARVALID && S_AXI_ARREADY) begin
      rdata <= rd_val;
      rresp <= rd_resp;
    end
  end

  logic unused_addr;
  assign unused_addr = ^{aw_addr[1:0], S_AXI_ARADDR[1:0]};

endmodule

// File: tb/tb_axi_tremolo_param_bank.sv
module tb_axi_tremolo_param_bank;
  localparam int NUM_CH = 2;
  localparam int PW     = 16;

  logic        ACLK = 1'b0;
  logic        ARESET;
  logic [5:0]  S_AXI_AWADDR, S_AXI_ARADDR;
  logic        S_AXI_AWVALID, S_AXI_AWREADY, S_AXI_WVALID, S_AXI_WREADY;
  logic [31:0] S_AXI_WDATA, S_AXI_RDATA;
  logic [3:0]  S_AXI_WSTRB;
  logic [1:0]  S_AXI_BRESP, S_AXI_RRESP;
  logic        S_AXI_BVALID, S_AXI_BREADY, S_AXI_ARVALID, S_AXI_ARREADY;
  logic        S_AXI_RVALID, S_AXI_RREADY, sample_tick;
  logic [NUM_CH*PW-1:0] depth_o, rate_o;
  logic [NUM_CH*2-1:0]  wave_o;
  logic [NUM_CH-1:0]    enable_o;

  int passed = 0, total = 0;

  always #5 ACLK = ~ACLK;

  axi_tremolo_param_bank #(.NUM_CH(NUM_CH), .PARAM_W(PW)) dut (
    .ACLK(ACLK), .ARESET(ARESET),
    .S_AXI_AWADDR(S_AXI_AWADDR), .S_AXI_AWVALID(S_AXI_AWVALID), .S_AXI_AWREADY(S_AXI_AWREADY),
    .S_AXI_WDATA(S_AXI_WDATA), .S_AXI_WSTRB(S_AXI_WSTRB), .S_AXI_WVALID(S_AXI_WVALID),
    .S_AXI_WREADY(S_AXI_WREADY), .S_AXI_BRESP(S_AXI_BRESP), .S_AXI_BVALID(S_AXI_BVALID),
    .S_AXI_BREADY(S_AXI_BREADY), .S_AXI_ARADDR(S_AXI_ARADDR), .S_AXI_ARVALID(S_AXI_ARVALID),
    .S_AXI_ARREADY(S_AXI_ARREADY), .S_AXI_RDATA(S_AXI_RDATA), .S_AXI_RRESP(S_AXI_RRESP),
    .S_AXI_RVALID(S_AXI_RVALID), .S_AXI_RREADY(S_AXI_RREADY), .sample_tick(sample_tick),
    .depth_o(depth_o), .rate_o(rate_o), .wave_o(wave_o), .enable_o(enable_o)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
  endtask

  task automatic cyc();
    @(posedge ACLK); #1;
  endtask

  task automatic pulse_tick();
    sample_tick = 1'b1;
    cyc();
    sample_tick = 1'b0;
  endtask

  // AW/W each raised after its own delay; optional sample_tick on the apply edge.
  task automatic axi_wr(input logic [5:0] a, input logic [31:0] d, input logic [3:0] s,
                        input int aw_dly, input int w_dly, input bit tick_apply,
                        output logic [1:0] resp);
    bit aw_done = 0, w_done = 0, hs_aw, hs_w;
    int k = 0;
    S_AXI_AWADDR = a; S_AXI_WDATA = d; S_AXI_WSTRB = s;
    while (!(aw_done && w_done) && k < 60) begin
      S_AXI_AWVALID = !aw_done && (k >= aw_dly);
      S_AXI_WVALID  = !w_done && (k >= w_dly);
      hs_aw = S_AXI_AWVALID && S_AXI_AWREADY;
      hs_w  = S_AXI_WVALID && S_AXI_WREADY;
      cyc();
      aw_done |= hs_aw; w_done |= hs_w; k++;
    end
    S_AXI_AWVALID = 0; S_AXI_WVALID = 0;
    sample_tick = tick_apply;
    S_AXI_BREADY = 1;
    do begin cyc(); sample_tick = 0; k++; end while (!S_AXI_BVALID && k < 60);
    chk("wr_timeout", 64'(k < 60), 64'd1);
    resp = S_AXI_BRESP;
    cyc();
    S_AXI_BREADY = 0;
  endtask

  task automatic axi_rd(input logic [5:0] a, output logic [31:0] d, output logic [1:0] resp);
    int k = 0;
    S_AXI_ARADDR = a; S_AXI_ARVALID = 1;
    while (!S_AXI_ARREADY && k < 60) begin cyc(); k++; end
    cyc();
    S_AXI_ARVALID = 0; S_AXI_RREADY = 1;
    while (!S_AXI_RVALID && k < 60) begin cyc(); k++; end
    chk("rd_timeout", 64'(k < 60), 64'd1);
    d = S_AXI_RDATA; resp = S_AXI_RRESP;
    cyc();
    S_AXI_RREADY = 0;
  endtask

  initial begin
    logic [1:0]  r;
    logic [31:0] d;
    bit stable;
    ARESET = 1; sample_tick = 0;
    S_AXI_AWADDR = 0; S_AXI_AWVALID = 0; S_AXI_WDATA = 0; S_AXI_WSTRB = 0; S_AXI_WVALID = 0;
    S_AXI_BREADY = 0; S_AXI_ARADDR = 0; S_AXI_ARVALID = 0; S_AXI_RREADY = 0;
    repeat (3) cyc();
    chk("rst_awready", S_AXI_AWREADY, 0);
    chk("rst_wready", S_AXI_WREADY, 0);
    chk("rst_arready", S_AXI_ARREADY, 0);
    chk("rst_outs", {depth_o, rate_o, wave_o, enable_o, S_AXI_BVALID, S_AXI_RVALID}, 0);
    ARESET = 0; #1;
    chk("post_rst_readys", {S_AXI_AWREADY, S_AXI_WREADY, S_AXI_ARREADY}, 3'b111);
    cyc();

    // 1: shadow writes do not reach active without commit
    axi_wr(6'h00, 32'h1234, 4'hF, 0, 0, 0, r); chk("t1_bresp0", r, 2'b00);
    axi_wr(6'h04, 32'h0040, 4'hF, 0, 0, 0, r); chk("t1_bresp1", r, 2'b00);
    chk("t1_depth_idle", depth_o, 0);
    chk("t1_rate_idle", rate_o, 0);
    axi_rd(6'h00, d, r); chk("t1_rd_depth", d, 32'h1234); chk("t1_rd_resp", r, 2'b00);

    // 2: commit then tick
    axi_wr(6'h20, 32'h1, 4'hF, 0, 0, 0, r);
    axi_rd(6'h24, d, r); chk("t2_status_pend", d, 1);
    sample_tick = 1; #1;
    chk("t2_depth_before_edge", depth_o, 0);
    cyc(); sample_tick = 0;
    chk("t2_depth", depth_o, 32'h0000_1234);
    chk("t2_rate", rate_o, 32'h0000_0040);
    axi_rd(6'h24, d, r); chk("t2_status_clr", d, 0);
    axi_rd(6'h20, d, r); chk("t2_ctrl_rd", d, 0);

    // 3: AW/W skew and byte strobes
    axi_wr(6'h10, 32'hAABBCCDD, 4'h2, 0, 3, 0, r); chk("t3_aw_first_bresp", r, 2'b00);
    chk("t3_single_b", S_AXI_BVALID, 0);
    axi_rd(6'h10, d, r); chk("t3_strb_byte1", d, 32'h0000_CC00);
    axi_wr(6'h14, 32'h55, 4'hF, 3, 0, 0, r); chk("t3_w_first_bresp", r, 2'b00);
    chk("t3_single_b2", S_AXI_BVALID, 0);
    axi_rd(6'h14, d, r); chk("t3_rd_rate1", d, 32'h55);
    axi_wr(6'h18, 32'hFFFF_FFFF, 4'hF, 0, 0, 0, r);
    axi_rd(6'h18, d, r); chk("t3_wave_mask", d, 3);
    axi_wr(6'h1C, 32'h1, 4'hF, 0, 0, 0, r);

    // 4: out-of-range and STATUS writes
    axi_rd(6'h3C, d, r); chk("t4_rd_slverr", r, 2'b10); chk("t4_rd_zero", d, 0);
    axi_rd(6'h28, d, r); chk("t4_rd28_slverr", r, 2'b10);
    axi_wr(6'h3C, 32'hFFFF_FFFF, 4'hF, 0, 0, 0, r); chk("t4_wr_slverr", r, 2'b10);
    axi_rd(6'h10, d, r); chk("t4_no_change", d, 32'h0000_CC00);
    axi_wr(6'h24, 32'h1, 4'hF, 0, 0, 0, r); chk("t4_status_wr_okay", r, 2'b00);
    axi_rd(6'h24, d, r); chk("t4_status_ro", d, 0);

    // 5: commit coinciding with tick
    axi_wr(6'h20, 32'h1, 4'hF, 0, 0, 1, r);
    chk("t5_no_xfer", depth_o, 32'h0000_1234);
    axi_rd(6'h24, d, r); chk("t5_pending", d, 1);
    pulse_tick();
    chk("t5_depth", depth_o, 32'hCC00_1234);
    chk("t5_rate", rate_o, 32'h0055_0040);
    chk("t5_wave", wave_o, 4'b1100);
    chk("t5_enable", enable_o, 2'b10);
    // shadow write on a transfer edge: active takes pre-write value
    axi_wr(6'h20, 32'h1, 4'hF, 0, 0, 0, r);
    axi_wr(6'h00, 32'h5678, 4'hF, 0, 0, 1, r);
    chk("t5_prewrite", depth_o, 32'hCC00_1234);
    axi_rd(6'h24, d, r); chk("t5_pend_clr", d, 0);
    // AUTO
    axi_wr(6'h20, 32'h2, 4'hF, 0, 0, 0, r);
    axi_rd(6'h20, d, r); chk("t5_auto_rd", d, 2);
    pulse_tick();
    chk("t5_auto_xfer", depth_o, 32'hCC00_5678);

    // 6: backpressure, then reset mid-wait
    S_AXI_ARADDR = 6'h14; S_AXI_ARVALID = 1;
    cyc(); S_AXI_ARVALID = 0;
    chk("t6_rvalid_lat", S_AXI_RVALID, 1);
    S_AXI_AWADDR = 6'h08; S_AXI_WDATA = 32'h9; S_AXI_WSTRB = 4'hF;
    S_AXI_AWVALID = 1; S_AXI_WVALID = 1;
    cyc(); S_AXI_AWVALID = 0; S_AXI_WVALID = 0;
    cyc(); cyc();
    stable = 1;
    for (int i = 0; i < 10; i++) begin
      if (!(S_AXI_BVALID && S_AXI_BRESP == 2'b00 && S_AXI_RVALID && S_AXI_RDATA == 32'h55 &&
            S_AXI_RRESP == 2'b00)) stable = 0;
      cyc();
    end
    chk("t6_hold_stable", stable, 1);
    ARESET = 1; #1;
    chk("t6_rst_valids", {S_AXI_BVALID, S_AXI_RVALID}, 0);
    chk("t6_rst_rdata", S_AXI_RDATA, 0);
    chk("t6_rst_outs", {depth_o, rate_o, wave_o, enable_o}, 0);
    chk("t6_rst_readys", {S_AXI_AWREADY, S_AXI_WREADY, S_AXI_ARREADY}, 0);
    cyc(); ARESET = 0; #1;
    chk("t6_readys_after", {S_AXI_AWREADY, S_AXI_WREADY, S_AXI_ARREADY}, 3'b111);
    S_AXI_BREADY = 1; S_AXI_RREADY = 1;
    cyc(); cyc();
    chk("t6_no_stale_resp", {S_AXI_BVALID, S_AXI_RVALID}, 0);
    S_AXI_BREADY = 0; S_AXI_RREADY = 0;
    axi_rd(6'h00, d, r); chk("t6_shadow_clr", d, 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
